// File: rtl/instruction_fetch_buffer.sv
// ---------------------------------------------------------------------------
// instruction_fetch_buffer
//
// Fetch stage between a combinational instruction ROM and the decoder.
// The block owns the program counter and drives it onto rom_address. Each
// cycle it may capture the returned ROM word, tagged with its address, into a
// small FIFO. The head of that FIFO is offered to decode over a valid/ready
// handshake. A redirect flushes every buffered word and restarts fetch at the
// new target.
//
// Parameters
//   ADDR_WIDTH  PC / ROM address width
//   DATA_WIDTH  instruction word width
//   DEPTH       FIFO entries (power of two, >= 2)
//   RESET_PC    PC value after reset
//
// Ports
//   clk              rising-edge clock
//   async_rst_n      asynchronous active-low reset
//   rom_address      ROM address (always the PC register)
//   rom_value        ROM word for rom_address, valid in the same cycle
//   fetch_enable     permits pushes; when low the PC is frozen
//   redirect_valid   flush the FIFO and load the PC from redirect_target
//   redirect_target  new fetch address
//   inst_valid       head entry present
//   inst_ready       decoder accepts the head entry
//   inst_data        head instruction word (zero when empty)
//   inst_pc          address of the head instruction (zero when empty)
// ---------------------------------------------------------------------------
module instruction_fetch_buffer #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_value,
  input  logic                  fetch_enable,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [ADDR_WIDTH-1:0] mem_pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];

  logic pop;
  logic push;

  assign inst_valid  = (count_q != '0);
  assign rom_address = pc_q;

  // Empty outputs are forced to zero so decode never sees stale words.
  assign inst_data = inst_valid ? mem_data_q[rd_ptr_q] : '0;
  assign inst_pc   = inst_valid ? mem_pc_q[rd_ptr_q]   : '0;

  always_comb begin
    pop  = inst_valid & inst_ready;
    // A full buffer can still take a word when the head leaves in the same
    // cycle. An empty buffer cannot pop, so there is no bypass path.
    push = fetch_enable & ~redirect_valid & ((count_q < DEPTH_C) | pop);

    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (redirect_valid) begin
      // A same-cycle pop is still taken by decode; every other entry is dropped.
      pc_d     = redirect_target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 1'b1;      // wraps modulo 2^ADDR_WIDTH
        wr_ptr_d = wr_ptr_q + 1'b1;  // DEPTH is a power of two
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // One storage slot per entry; a slot loads only when it is the write target.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
        mem_pc_q[gi]   <= '0;
        mem_data_q[gi] <= '0;
      end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
        mem_pc_q[gi]   <= pc_q;
        mem_data_q[gi] <= rom_value;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// ---------------------------------------------------------------------------
// Bench for instruction_fetch_buffer. The ROM returns 16'hA000 | address.
// A queue model of the buffer predicts the outputs each cycle. Accepted
// instructions are logged and a few literal expectations pin the sequence.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_buffer;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic [9:0]  rom_address;
  logic [15:0] rom_value;
  logic        fetch_enable;
  logic        redirect_valid;
  logic [9:0]  redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_data;
  logic [9:0]  inst_pc;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [9:0]  pc;
    logic [15:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [9:0]  mpc;
  logic [9:0]  acc_pc[$];
  logic [15:0] acc_data[$];

  always #5 clk = ~clk;

  assign rom_value = 16'hA000 | {6'h0, rom_address};

  instruction_fetch_buffer #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(16),
    .DEPTH(2),
    .RESET_PC(10'h000)
  ) dut (
    .clk(clk),
    .async_rst_n(async_rst_n),
    .rom_address(rom_address),
    .rom_value(rom_value),
    .fetch_enable(fetch_enable),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered 1 time unit after a rising edge. Drives inputs, checks outputs
  // mid-cycle against the model, then advances the model across the edge.
  task automatic step(input logic fe, input logic rv, input logic [9:0] rt, input logic rdy);
    logic        exp_valid;
    logic [9:0]  exp_pc;
    logic [15:0] exp_data;
    logic        m_pop;
    logic        m_push;
    fetch_enable    = fe;
    redirect_valid  = rv;
    redirect_target = rt;
    inst_ready      = rdy;
    #3;
    exp_valid = (mq.size() != 0);
    exp_pc    = exp_valid ? mq[0].pc   : 10'h000;
    exp_data  = exp_valid ? mq[0].data : 16'h0000;
    chk("inst_valid",  32'(inst_valid),  32'(exp_valid));
    chk("inst_pc",     32'(inst_pc),     32'(exp_pc));
    chk("inst_data",   32'(inst_data),   32'(exp_data));
    chk("rom_address", 32'(rom_address), 32'(mpc));
    m_pop  = exp_valid && rdy;
    m_push = fe && !rv && ((mq.size() < 2) || m_pop);
    if (inst_valid && rdy) begin
      acc_pc.push_back(inst_pc);
      acc_data.push_back(inst_data);
      $display("accept pc=%03h data=%04h (fe=%0b rv=%0b)", inst_pc, inst_data, fe, rv);
    end else begin
      $display("cycle  valid=%0b rom=%03h (fe=%0b rv=%0b rdy=%0b)", inst_valid, rom_address, fe, rv, rdy);
    end
    @(posedge clk);
    if (m_pop) void'(mq.pop_front());
    if (rv) begin
      mq.delete();
      mpc = rt;
    end else if (m_push) begin
      mq.push_back({mpc, 16'hA000 | {6'h0, mpc}});
      mpc = mpc + 10'h001;
    end
    #1;
  endtask

  initial begin
    async_rst_n     = 1'b0;
    fetch_enable    = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 10'h000;
    inst_ready      = 1'b0;
    mpc             = 10'h000;

    // Reset state, before any clock edge
    #2;
    chk("reset_valid", 32'(inst_valid),  32'h0);
    chk("reset_rom",   32'(rom_address), 32'h000);
    chk("reset_data",  32'(inst_data),   32'h0000);
    @(posedge clk);
    #1;
    async_rst_n = 1'b1;

    // Streaming: one per cycle after a one-cycle fill
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10'h000, 1'b1);

    // Decoder stalls: buffer fills to two, PC freezes
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'h000, 1'b0);
    chk("stall_rom_frozen", 32'(rom_address), 32'h005);
    chk("stall_head_pc",    32'(inst_pc),     32'h003);

    // Release: full + pop keeps streaming
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'h000, 1'b1);
    chk("order_0", 32'(acc_pc[0]), 32'h000);
    chk("order_1", 32'(acc_pc[1]), 32'h001);
    chk("order_3", 32'(acc_pc[3]), 32'h003);
    chk("order_5", 32'(acc_pc[5]), 32'h005);

    // Redirect with buffer full
    step(1'b1, 1'b1, 10'h019, 1'b0);
    chk("redir_rom", 32'(rom_address), 32'h019);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'h000, 1'b1);
    chk("redir_count",  32'(acc_pc.size()), 32'd8);
    chk("redir_pc",     32'(acc_pc[6]),     32'h019);
    chk("redir_data",   32'(acc_data[6]),   32'hA019);
    chk("redir_next",   32'(acc_pc[7]),     32'h01A);

    // Redirect near the top of the address space, pop in the same cycle
    step(1'b1, 1'b1, 10'h3FE, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'h000, 1'b1);
    chk("redir_pop_pc", 32'(acc_pc[8]),  32'h01B);
    chk("wrap_3fe",     32'(acc_pc[9]),  32'h3FE);
    chk("wrap_3ff",     32'(acc_pc[10]), 32'h3FF);
    chk("wrap_000",     32'(acc_pc[11]), 32'h000);
    chk("wrap_001",     32'(acc_pc[12]), 32'h001);
    chk("wrap_data",    32'(acc_data[11]), 32'hA000);

    // Fill, then drain with fetch disabled
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 10'h000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 10'h000, 1'b1);
    chk("drain_valid", 32'(inst_valid),  32'h0);
    chk("drain_rom",   32'(rom_address), 32'h004);
    chk("drain_last",  32'(acc_pc[14]),  32'h003);

    // Redirect while fetch is disabled still flushes and loads PC
    step(1'b1, 1'b0, 10'h000, 1'b0);
    step(1'b0, 1'b1, 10'h100, 1'b0);
    chk("redir_fe0_valid", 32'(inst_valid),  32'h0);
    chk("redir_fe0_rom",   32'(rom_address), 32'h100);
    step(1'b0, 1'b0, 10'h000, 1'b1);

    // Stream, then asynchronous reset between edges
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'h000, 1'b1);
    #2;
    async_rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(inst_valid),  32'h0);
    chk("arst_data",  32'(inst_data),   32'h0000);
    chk("arst_pc",    32'(inst_pc),     32'h000);
    chk("arst_rom",   32'(rom_address), 32'h000);
    mq.delete();
    mpc = 10'h000;
    @(posedge clk);
    #1;
    async_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10'h000, 1'b1);
    chk("post_rst_first", 32'(acc_pc[17]),    32'h000);
    chk("post_rst_third", 32'(acc_pc[19]),    32'h002);
    chk("total_accepts",  32'(acc_pc.size()), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_buffer.md
# instruction_fetch_buffer

Fetch stage that sits directly upstream of the combinational instruction ROM and downstream-feeds the decoder. It owns the program counter, drives the ROM address, captures each returned 16-bit word together with its address into a small FIFO, and presents instructions to decode over a valid/ready handshake. It also accepts branch/jump redirects, which flush buffered words and restart fetch at the new target.

## Interface
- ADDR_WIDTH, 10, ROM address / PC width
- DATA_WIDTH, 16, instruction width
- DEPTH, 2, buffer entries; power of two, >= 2
- RESET_PC, 0, PC value after reset
- clk  in  1  rising-edge clock
- async_rst_n  in  1  reset, asynchronous, active-low
- rom_address  out  ADDR_WIDTH  ROM address; always equals PC register
- rom_value  in  DATA_WIDTH  ROM word for rom_address, valid same cycle (combinational ROM)
- fetch_enable  in  1  permits pushes; 0 freezes PC (buffer still drains)
- redirect_valid  in  1  flush and load PC from redirect_target
- redirect_target  in  ADDR_WIDTH  new fetch address
- inst_valid  out  1  head entry present
- inst_ready  in  1  decoder accepts head entry
- inst_data  out  DATA_WIDTH  head instruction word
- inst_pc  out  ADDR_WIDTH  address of head instruction

## Operation
- State: PC register, DEPTH-entry FIFO of {pc, word}, read/write pointers, occupancy counter (width clog2(DEPTH+1)).
- pop = inst_valid & inst_ready.
- push = fetch_enable & ~redirect_valid & (count < DEPTH | pop). Push writes {PC, rom_value}; PC <= PC + 1, wrapping modulo 2^ADDR_WIDTH (0x3FF -> 0x000).
- No push: PC holds; rom_address unchanged.
- Full and pop in same cycle: push also allowed; count unchanged.
- Empty: push and pop cannot coincide (no bypass); new word appears next cycle.
- redirect_valid: PC <= redirect_target; count, pointers <= 0; no push that cycle. A pop in the same cycle still counts as accepted by decode; all other entries discarded.
- redirect_valid and fetch_enable=0: flush and PC load still occur.
- inst_valid = (count != 0). inst_data/inst_pc = head entry when valid, all zeros when empty.
- Entries leave strictly in fetch order; no duplication, no loss except on redirect flush.

## Timing
- Reset (async, no clock needed): PC=RESET_PC, count=0, pointers=0, inst_valid=0, inst_data=0, inst_pc=0, rom_address=RESET_PC.
- Fetch-to-output latency: 1 cycle (word sampled at edge N, inst_valid high after edge N).
- First instruction after reset release: inst_valid high after first active edge with fetch_enable=1.
- Redirect asserted in cycle N: rom_address=target after edge N; target instruction valid after edge N+1 (2-cycle bubble to decode).
- Steady state with inst_ready=1: one instruction per cycle.
- inst_ready low: inst_valid/inst_data/inst_pc held stable until accepted.
- Reset asserted mid-operation clears all state immediately; buffered entries lost.

## Test plan
- ROM model returns 16'hA000|address; release reset, fetch_enable=1, inst_ready=1 -> inst_valid rises after first edge; inst_pc 0x000,0x001,0x002…, inst_data 0xA000,0xA001… one per cycle.
- Hold inst_ready=0 for 5 cycles -> count reaches 2, rom_address freezes at 0x002, outputs stable at pc 0x000; release -> 0x000,0x001,0x002 in order, no gaps/duplicates.
- With buffer full, pulse redirect_valid, redirect_target=0x019 -> next inst_valid carries inst_pc 0x019/data 0xA019 two edges later; no stale 0x00x entries appear.
- redirect_target=0x3FE, inst_ready=1 -> inst_pc 0x3FE,0x3FF,0x000,0x001.
- Buffer holding 2 entries, fetch_enable=0, inst_ready=1 -> both drain, then inst_valid=0 and rom_address constant; redirect with fetch_enable=0 still loads PC and empties buffer.
- Assert async_rst_n=0 between clock edges mid-stream -> inst_valid, inst_data, inst_pc go 0 and rom_address=RESET_PC without a clock edge.
